// File: rtl/mbus_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package mbus_arb_pkg;

    // Sequencer states; the encoding is visible on arb_stat for debug.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_ACK  = 2'd2
    } arb_state_e;

    // Master indices.
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    // Width of the ACC wait counter; covers a timeout of up to 255 cycles.
    localparam int CNT_W = 8;

    // Round-robin choice between two requesters. A lone requester always
    // wins; on a tie the master that was not granted last goes next.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic g;
        case (req)
            2'b01:   g = M_CPU;
            2'b10:   g = M_AUX;
            default: g = ~last;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mbus_arb_if.sv
// Bus interfaces: one requester port per master and the shared slave bus.

// Requester side: the master holds req with a stable address, data and
// write flag until it sees ack.
interface mbus_m_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 32
);
    logic                 req;
    logic [ADDR_SIZE-1:0] aout;
    logic [WIDTH-1:0]     dout;
    logic                 wen;
    logic [WIDTH-1:0]     din;
    logic                 ack;

    // Seen from the requesting master.
    modport master (output req, aout, dout, wen, input din, ack);
    // Seen from the arbiter.
    modport slave  (input req, aout, dout, wen, output din, ack);
endinterface

// Slave bus: address, write data and write enable out, read data and a
// ready strobe back.
interface mbus_s_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 32
);
    logic [ADDR_SIZE-1:0] aout;
    logic [WIDTH-1:0]     dout;
    logic                 wen;
    logic [WIDTH-1:0]     din;
    logic                 ready;

    // Seen from the arbiter, which drives the bus.
    modport master (output aout, dout, wen, input din, ready);
    // Seen from the memory.
    modport slave  (input aout, dout, wen, output din, ready);
endinterface

// File: rtl/mbus_arb_rr2.sv
// Two-way round-robin picker: combinational grant plus the register that
// remembers which master was granted most recently.
module arb_rr2
    import mbus_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,      // current requests
    input  logic       upd_i,      // a grant has completed this cycle
    input  logic       upd_idx_i,  // index of the master just served
    output logic       grant_o     // master to serve next
);

    logic last_q, last_d;

    // Record the completed grant so the other master wins the next tie.
    always_comb begin
        last_d = last_q;
        if (upd_i) last_d = upd_idx_i;
    end

    // Reset to the aux master so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) last_q <= M_AUX;
        else       last_q <= last_d;
    end

    assign grant_o = rr_pick(req_i, last_q);

endmodule

// File: rtl/mbus_arb.sv
// Two-master memory bus arbiter and sequencer with wait states and a
// slave timeout. IDLE picks a master, ACC holds its request on the bus
// until ready or timeout, ACK returns a one-cycle acknowledge.
module mbus_arb
    import mbus_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 32,
    parameter int TMO       = 15    // 0 disables the timeout
) (
    input  logic        clk,
    input  logic        reset,
    mbus_m_if.slave     m0,         // CPU
    mbus_m_if.slave     m1,         // DMA / debug
    mbus_s_if.master    s,
    output logic        err,
    output logic [1:0]  arb_stat
);

    localparam bit             TMO_EN   = (TMO != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TMO - 1) : '0;

    arb_state_e           state_q, state_d;
    logic                 sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     din0_q, din0_d;
    logic [WIDTH-1:0]     din1_q, din1_d;
    logic                 err_q, err_d;

    logic [1:0]           req;
    logic                 rr_grant;
    logic                 rr_upd;
    logic [ADDR_SIZE-1:0] sel_aout;
    logic [WIDTH-1:0]     sel_dout;
    logic                 sel_wen;

    assign req = {m1.req, m0.req};

    arb_rr2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .upd_i     (rr_upd),
        .upd_idx_i (sel_q),
        .grant_o   (rr_grant)
    );

    // Only the selected master's request reaches the bus.
    assign sel_aout = (sel_q == M_AUX) ? m1.aout : m0.aout;
    assign sel_dout = (sel_q == M_AUX) ? m1.dout : m0.dout;
    assign sel_wen  = (sel_q == M_AUX) ? m1.wen  : m0.wen;

    // Next-state logic: arbitration, wait counting, read capture, timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        din0_d  = din0_q;
        din1_d  = din1_q;
        err_d   = 1'b0;
        rr_upd  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    sel_d   = rr_grant;
                    state_d = ARB_ACC;
                end
            end
            ARB_ACC: begin
                // Saturate so a disabled timeout never wraps the counter.
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (s.ready) begin
                    if (!sel_wen) begin
                        if (sel_q == M_AUX) din1_d = s.din;
                        else                din0_d = s.din;
                    end
                    cnt_d   = '0;
                    rr_upd  = 1'b1;
                    state_d = ARB_ACK;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    // Abort: ack with err, leave read data untouched.
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rr_upd  = 1'b1;
                    state_d = ARB_ACK;
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and data registers; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            sel_q   <= M_CPU;
            cnt_q   <= '0;
            din0_q  <= '0;
            din1_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            din0_q  <= din0_d;
            din1_q  <= din1_d;
            err_q   <= err_d;
        end
    end

    // Slave bus carries the selected request only during ACC, zero otherwise.
    always_comb begin
        s.aout = '0;
        s.dout = '0;
        s.wen  = 1'b0;
        if (state_q == ARB_ACC) begin
            s.aout = sel_aout;
            s.dout = sel_dout;
            s.wen  = sel_wen;
        end
    end

    assign m0.din   = din0_q;
    assign m1.din   = din1_q;
    assign m0.ack   = (state_q == ARB_ACK) && (sel_q == M_CPU);
    assign m1.ack   = (state_q == ARB_ACK) && (sel_q == M_AUX);
    assign err      = err_q;     // set only during an ACK that followed a timeout
    assign arb_stat = state_q;

endmodule

// File: tb/tb_mbus_arb.sv
// Bench for mbus_arb: per-master drivers push expected results into
// queues; a slave responder and an ack monitor compare against them.
`timescale 1ns/1ps
module tb_mbus_arb;
    import mbus_arb_pkg::*;

    localparam int W   = 32;
    localparam int A   = 32;
    localparam int TMO = 4;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] dout;
        int          w;      // ACC cycles the slave stalls before ready
        logic        err;
        logic [31:0] din;    // master's din expected after this ack
        int          len;    // expected number of ACC cycles
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mbus_m_if #(.WIDTH(W), .ADDR_SIZE(A)) m0_if ();
    mbus_m_if #(.WIDTH(W), .ADDR_SIZE(A)) m1_if ();
    mbus_s_if #(.WIDTH(W), .ADDR_SIZE(A)) s_if ();
    logic       err;
    logic [1:0] arb_stat;

    mbus_arb #(.WIDTH(W), .ADDR_SIZE(A), .TMO(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .err      (err),
        .arb_stat (arb_stat)
    );

    logic [1:0]   req_v = 2'b00;
    logic [1:0]   wen_v = 2'b00;
    logic [A-1:0] aout_v [2];
    logic [W-1:0] dout_v [2];
    logic         s_ready_v = 1'b0;
    logic [W-1:0] s_din_v = '0;

    assign m0_if.req  = req_v[0];
    assign m0_if.aout = aout_v[0];
    assign m0_if.dout = dout_v[0];
    assign m0_if.wen  = wen_v[0];
    assign m1_if.req  = req_v[1];
    assign m1_if.aout = aout_v[1];
    assign m1_if.dout = dout_v[1];
    assign m1_if.wen  = wen_v[1];
    assign s_if.ready = s_ready_v;
    assign s_if.din   = s_din_v;

    logic [1:0]   ack_w;
    logic [W-1:0] din_w [2];
    assign ack_w    = {m1_if.ack, m0_if.ack};
    assign din_w[0] = m0_if.din;
    assign din_w[1] = m1_if.din;

    int tests = 0;
    int fails = 0;

    txn_t q0[$];
    txn_t q1[$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] din_model [2];
    logic [31:0] hold_din  [2];
    logic        model_last = 1'b1;
    int          acc_len = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] base(input int m);
        return (m == 0) ? 32'h0000_1000 : 32'h0000_2000;
    endfunction

    // Issue n transactions for master m. fw/fwen >= 0 force the stall count
    // and write flag. lat reports posedges from req to ack of the last one.
    task automatic drive(input int m, input int n, input int max_gap,
                         input int fw, input int fwen, output int lat);
        txn_t t;
        int   gap;
        int   k;
        lat = 0;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
                req_v[m] = 1'b0;
                repeat (gap) begin
                    aout_v[m] = $urandom;
                    dout_v[m] = $urandom;
                    wen_v[m]  = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            t.wen  = (fwen >= 0) ? 1'(fwen) : 1'($urandom);
            t.addr = base(m) | (32'($urandom_range(0, 7)) << 2);
            t.dout = $urandom;
            t.w    = (fw >= 0) ? fw : int'($urandom_range(0, 5));
            t.err  = (TMO != 0) && (t.w >= TMO);
            t.len  = t.err ? TMO : t.w + 1;
            if (!t.err) begin
                if (t.wen) mem_model[t.addr] = t.dout;
                else din_model[m] = mem_model.exists(t.addr) ? mem_model[t.addr] : init_val(t.addr);
            end
            t.din = din_model[m];
            if (m == 0) q0.push_back(t); else q1.push_back(t);
            aout_v[m] = t.addr;
            dout_v[m] = t.dout;
            wen_v[m]  = t.wen;
            req_v[m]  = 1'b1;
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (!ack_w[m] && k < 60);
            lat = k;
            if (!ack_w[m]) begin
                check($sformatf("ack_wait_m%0d", m), 64'(ack_w[m]), 64'd1);
                req_v[m] = 1'b0;
                return;
            end
        end
        req_v[m] = 1'b0;
    endtask

    // Slave responder: stalls each access by its planned count, checks the
    // bus against the granted master's pending request, checks arbitration.
    initial begin : slave
        int         k;
        txn_t       cur;
        logic       gm, exp_g;
        logic [1:0] idle_req;
        k = 0;
        idle_req = 2'b00;
        cur = '{wen: 1'b0, addr: 32'd0, dout: 32'd0, w: 0, err: 1'b0, din: 32'd0, len: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                k = 0;
                s_ready_v = 1'b0;
            end else if (arb_stat == ARB_ACC) begin
                if (k == 0) begin
                    gm    = (s_if.aout[13:12] == 2'b10);
                    exp_g = (idle_req == 2'b11) ? ~model_last : idle_req[1];
                    check("grant", 64'(gm), 64'(exp_g));
                    if (gm && q1.size() > 0)       cur = q1[0];
                    else if (!gm && q0.size() > 0) cur = q0[0];
                    else check("grant_unexpected", 64'd0, 64'd1);
                end
                check("s_aout", 64'(s_if.aout), 64'(cur.addr));
                check("s_wen", 64'(s_if.wen), 64'(cur.wen));
                if (cur.wen) check("s_dout", 64'(s_if.dout), 64'(cur.dout));
                s_ready_v = (k >= cur.w);
                if (s_ready_v && !cur.wen)
                    s_din_v = slave_mem.exists(cur.addr) ? slave_mem[cur.addr] : init_val(cur.addr);
                else
                    s_din_v = $urandom;
                if (s_ready_v && cur.wen) slave_mem[cur.addr] = s_if.dout;
                k++;
                acc_len = k;
            end else begin
                k = 0;
                if (arb_stat == ARB_IDLE) idle_req = req_v;
                check("bus_quiet", 64'({s_if.aout, s_if.dout, s_if.wen} != '0), 64'd0);
                // ready outside ACC must have no effect
                s_ready_v = 1'($urandom);
                s_din_v   = $urandom;
            end
        end
    end

    // Ack monitor: pops the acked master's expectation and checks the result.
    initial begin : monitor
        txn_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_last  = 1'b1;
                hold_din[0] = '0;
                hold_din[1] = '0;
            end else begin
                if (ack_w == 2'b11) check("dual_ack", 64'(ack_w), 64'd1);
                for (int m = 0; m < 2; m++) begin
                    if (ack_w[m]) begin
                        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                            check($sformatf("ack_unexpected_m%0d", m), 64'd1, 64'd0);
                        end else begin
                            if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
                            check("ack_state", 64'(arb_stat), 64'(ARB_ACK));
                            check($sformatf("rdata_m%0d", m), 64'(din_w[m]), 64'(e.din));
                            check("err", 64'(err), 64'(e.err));
                            check("acc_len", 64'(acc_len), 64'(e.len));
                            hold_din[m] = e.din;
                            model_last  = 1'(m);
                        end
                    end
                end
                if (ack_w == 2'b00) check("err_idle", 64'(err), 64'd0);
                check("din_hold_m0", 64'(din_w[0]), 64'(hold_din[0]));
                check("din_hold_m1", 64'(din_w[1]), 64'(hold_din[1]));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   lat, l0, l1, k;
        txn_t t;
        aout_v[0] = '0; aout_v[1] = '0;
        dout_v[0] = '0; dout_v[1] = '0;
        din_model[0] = '0; din_model[1] = '0;
        hold_din[0] = '0; hold_din[1] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stat", 64'(arb_stat), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ack", 64'(ack_w), 64'd0);
        check("rst_din0", 64'(din_w[0]), 64'd0);
        check("rst_din1", 64'(din_w[1]), 64'd0);
        check("rst_bus", 64'({s_if.aout, s_if.dout, s_if.wen} != '0), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single zero-wait read, wait-state write, timeout read
        drive(0, 1, 0, 0, 0, lat);
        check("lat_read", 64'(lat), 64'd2);
        @(posedge clk); #1;
        drive(1, 1, 0, 2, 1, lat);
        check("lat_write_ws", 64'(lat), 64'd4);
        @(posedge clk); #1;
        drive(0, 1, 0, 5, 0, lat);
        check("lat_timeout", 64'(lat), 64'(1 + TMO));
        @(posedge clk); #1;
        drive(0, 1, 0, 1, 0, lat);
        check("lat_after_tmo", 64'(lat), 64'd3);
        @(posedge clk); #1;

        // Continuous contention, then randomized traffic
        fork
            drive(0, 4, 0, 0, -1, l0);
            drive(1, 4, 0, 0, -1, l1);
        join
        fork
            drive(0, 40, 3, -1, -1, l0);
            drive(1, 40, 3, -1, -1, l1);
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a stalled read
        t = '{wen: 1'b0, addr: base(0), dout: 32'd0, w: 9, err: 1'b1, din: 32'd0, len: TMO};
        q0.push_back(t);
        aout_v[0] = t.addr; wen_v[0] = 1'b0; req_v[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (arb_stat != ARB_ACC && k < 20);
        check("reach_acc", 64'(arb_stat), 64'(ARB_ACC));
        @(posedge clk); #1;
        reset = 1'b1;
        req_v = 2'b00;
        @(posedge clk); #1;
        check("mid_rst_stat", 64'(arb_stat), 64'd0);
        check("mid_rst_ack", 64'(ack_w), 64'd0);
        check("mid_rst_wen", 64'(s_if.wen), 64'd0);
        check("mid_rst_din0", 64'(din_w[0]), 64'd0);
        check("mid_rst_din1", 64'(din_w[1]), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        q0.delete();
        q1.delete();
        din_model[0] = '0; din_model[1] = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        // After reset the CPU must win the first tie
        fork
            drive(0, 2, 0, 0, -1, l0);
            drive(1, 2, 0, 0, -1, l1);
        join
        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
